// File: rtl/debounce_pkg.sv
// Shared constants and elaboration helpers for the push-button debouncer.
package debounce_pkg;

   localparam int unsigned DEB_SYNC_STAGES_DEF   = 2;
   localparam int unsigned DEB_STABLE_CYCLES_DEF = 1000000;
   localparam int unsigned DEB_REPEAT_DELAY_DEF  = 50000000;
   localparam int unsigned DEB_REPEAT_PERIOD_DEF = 10000000;

   // Ceiling log2; clog2(N+1) is the width needed to hold the value N.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Larger of two unsigned values.
   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single button channel: synchronizer, stability counter, edge pulses.
// Auto-repeat of rise pulses is built only when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  ,parameter int unsigned REPEAT_DELAY  = DEB_REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEF
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic rise_c
);

   localparam int unsigned CNT_W = clog2(STABLE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned RPT_W = clog2(umax(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_phase_q, rpt_phase_d;
`endif

   // Next-state: shift synchronizer, count disagreement, flip level at terminal count.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      if (sync_q[SYNC_STAGES-1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
         level_d = ~level_q;
         cnt_d   = '0;
         rise_d  = ~level_q;
         fall_d  = level_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      // Repeat timer: first interval is REPEAT_DELAY, then REPEAT_PERIOD while held.
      rpt_d       = rpt_q;
      rpt_phase_d = rpt_phase_q;
      if (rise_d || fall_d || !level_q) begin
         rpt_d       = '0;
         rpt_phase_d = 1'b0;
      end else if (!rpt_phase_q) begin
         if (rpt_q == RPT_W'(REPEAT_DELAY - 1)) begin
            rise_d      = 1'b1;
            rpt_d       = '0;
            rpt_phase_d = 1'b1;
         end else begin
            rpt_d = rpt_q + RPT_W'(1);
         end
      end else begin
         if (rpt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
            rise_d = 1'b1;
            rpt_d  = '0;
         end else begin
            rpt_d = rpt_q + RPT_W'(1);
         end
      end
`endif
   end

   // State registers with synchronous reset that overrides any count in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         rpt_q       <= '0;
         rpt_phase_q <= 1'b0;
`endif
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         rpt_q       <= rpt_d;
         rpt_phase_q <= rpt_phase_d;
`endif
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign rise_c  = rise_d;

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: NUM_CH independent debounce slices
// plus a registered OR of all rise pulses.
// Optional auto-repeat of rise pulses: define BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY  = DEB_REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] btn,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              any_rise
);

   // Reject parameter values the slices cannot implement.
   if (NUM_CH < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
      $error("btn_debounce_multi: illegal parameter value");
   end

   logic [NUM_CH-1:0] rise_nxt;
   logic              any_rise_q, any_rise_d;

   // One independent slice per button.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_ch #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        ,.REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .btn_i   (btn[i]),
         .level_o (level[i]),
         .rise_o  (rise_pulse[i]),
         .fall_o  (fall_pulse[i]),
         .rise_c  (rise_nxt[i])
      );
   end

   // OR of next-cycle rise pulses so any_rise lines up with rise_pulse.
   always_comb begin
      any_rise_d = |rise_nxt;
   end

   // any_rise register.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_rise_q <= 1'b0;
      end else begin
         any_rise_q <= any_rise_d;
      end
   end

   assign any_rise = any_rise_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios with literal expectations,
// then random bouncing stimulus, all checked every cycle against a window model.
module tb_btn_debounce_multi;

   localparam int NUM_CH  = 2;
   localparam int SYNC_ST = 2;
   localparam int STABLE  = 4;
   localparam int RDELAY  = 10;
   localparam int RPERIOD = 3;
   localparam int MAXE    = 12000;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] btn = '0;
   logic [NUM_CH-1:0] level, rise_pulse, fall_pulse;
   logic              any_rise;

   int n_chk  = 0;
   int n_fail = 0;

   btn_debounce_multi #(
      .NUM_CH        (NUM_CH),
      .SYNC_STAGES   (SYNC_ST),
      .STABLE_CYCLES (STABLE),
      .REPEAT_DELAY  (RDELAY),
      .REPEAT_PERIOD (RPERIOD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .level      (level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_rise   (any_rise)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int ch, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s ch%0d: got %b expected %b at %0t", nm, ch, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: btn captured per edge; level flips at edge e when the
   // synchronized value seen at each of the last STABLE edges (all after the
   // last reset/flip) disagreed with the level.
   bit bh [NUM_CH][MAXE];
   int last_rst = -1;
   int last_flip [NUM_CH];
   int rise_edge [NUM_CH];
   bit m_lvl  [NUM_CH];
   bit m_rise [NUM_CH];
   bit m_fall [NUM_CH];
   bit valid = 1'b0;

   // Synchronizer output that the counter samples at edge e.
   function automatic bit sync_seen(input int ch, input int e);
      int idx;
      idx = e - SYNC_ST;
      if (idx > last_rst && idx >= 0) return bh[ch][idx];
      return 1'b0;
   endfunction

   task automatic model_step(input int e, input logic rs, input logic [NUM_CH-1:0] bs);
      bit ok;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         bh[ch][e]  = bs[ch];
         m_rise[ch] = 1'b0;
         m_fall[ch] = 1'b0;
         if (rs) begin
            m_lvl[ch]     = 1'b0;
            last_flip[ch] = e;
         end else if (valid) begin
            ok = (e - STABLE + 1 > last_flip[ch]);
            for (int k = e - STABLE + 1; k <= e && ok; k++)
               if (sync_seen(ch, k) == m_lvl[ch]) ok = 1'b0;
            if (ok) begin
               m_lvl[ch]     = ~m_lvl[ch];
               last_flip[ch] = e;
               if (m_lvl[ch]) begin
                  m_rise[ch]    = 1'b1;
                  rise_edge[ch] = e;
               end else begin
                  m_fall[ch] = 1'b1;
               end
            end else if (REP_ON && m_lvl[ch] && (e - rise_edge[ch] >= RDELAY) &&
                         ((e - rise_edge[ch] - RDELAY) % RPERIOD == 0)) begin
               m_rise[ch] = 1'b1;
            end
         end
      end
      if (rs) begin
         valid    = 1'b1;
         last_rst = e;
      end
   endtask

   // Compare process: update model at each edge, check outputs 1 time unit later.
   initial begin : cmp
      int          e;
      logic        rs;
      logic [NUM_CH-1:0] bs;
      bit          exp_any;
      e = 0;
      forever begin
         @(posedge clk);
         rs = rst;
         bs = btn;
         if (e < MAXE) model_step(e, rs, bs);
         #1;
         if (valid && e < MAXE) begin
            exp_any = 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
               chk("model_level", ch, level[ch], m_lvl[ch]);
               chk("model_rise", ch, rise_pulse[ch], m_rise[ch]);
               chk("model_fall", ch, fall_pulse[ch], m_fall[ch]);
               exp_any = exp_any | m_rise[ch];
            end
            chk("model_any_rise", 0, any_rise, exp_any);
         end
         e++;
      end
   end

   // Stimulus with literal expectations for the directed scenarios.
   initial begin : stim
      int hold [NUM_CH];
      rst = 1'b1;
      btn = '0;
      repeat (3) tick();
      chk("rst_level", 0, level[0], 1'b0);
      chk("rst_rise", 0, rise_pulse[0], 1'b0);
      chk("rst_fall", 1, fall_pulse[1], 1'b0);
      chk("rst_any", 0, any_rise, 1'b0);
      rst = 1'b0;
      repeat (8) tick();

      // Clean press, then hold for auto-repeat.
      btn[0] = 1'b1;
      repeat (5) tick();
      chk("press_e5_level", 0, level[0], 1'b0);
      tick();
      chk("press_e6_level", 0, level[0], 1'b1);
      chk("press_e6_rise", 0, rise_pulse[0], 1'b1);
      chk("press_e6_any", 0, any_rise, 1'b1);
      tick();
      chk("press_e7_rise", 0, rise_pulse[0], 1'b0);
      chk("press_e7_any", 0, any_rise, 1'b0);
      repeat (8) tick();
      chk("hold_e15_rise", 0, rise_pulse[0], 1'b0);
      tick();
      chk("hold_e16_rise", 0, rise_pulse[0], REP_ON);
      tick();
      chk("hold_e17_rise", 0, rise_pulse[0], 1'b0);
      repeat (2) tick();
      chk("hold_e19_rise", 0, rise_pulse[0], REP_ON);
      repeat (3) tick();
      chk("hold_e22_rise", 0, rise_pulse[0], REP_ON);

      // Bouncy release: 0,1,0 then hold 0.
      btn[0] = 1'b0;
      tick();
      btn[0] = 1'b1;
      tick();
      btn[0] = 1'b0;
      repeat (5) tick();
      chk("release_e5_level", 0, level[0], 1'b1);
      chk("release_e5_fall", 0, fall_pulse[0], 1'b0);
      tick();
      chk("release_e6_fall", 0, fall_pulse[0], 1'b1);
      chk("release_e6_level", 0, level[0], 1'b0);
      tick();
      chk("release_e7_fall", 0, fall_pulse[0], 1'b0);

      // Glitch: three cycles high is one short of terminal count.
      repeat (4) tick();
      btn[0] = 1'b1;
      repeat (3) tick();
      btn[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch_level", 0, level[0], 1'b0);
         chk("glitch_rise", 0, rise_pulse[0], 1'b0);
      end

      // Simultaneous rise on ch0 and fall on ch1.
      btn[1] = 1'b1;
      repeat (8) tick();
      chk("simul_pre_level1", 1, level[1], 1'b1);
      btn[0] = 1'b1;
      btn[1] = 1'b0;
      repeat (6) tick();
      chk("simul_rise0", 0, rise_pulse[0], 1'b1);
      chk("simul_fall1", 1, fall_pulse[1], 1'b1);
      chk("simul_rise1", 1, rise_pulse[1], 1'b0);
      chk("simul_any", 0, any_rise, 1'b1);

      // Reset mid-count.
      btn[0] = 1'b0;
      repeat (8) tick();
      btn[0] = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("midrst_level", 0, level[0], 1'b0);
      chk("midrst_rise", 0, rise_pulse[0], 1'b0);
      rst = 1'b0;
      repeat (5) tick();
      chk("postrst_e5_level", 0, level[0], 1'b0);
      tick();
      chk("postrst_e6_level", 0, level[0], 1'b1);
      chk("postrst_e6_rise", 0, rise_pulse[0], 1'b1);

      // Random bouncing with occasional resets.
      for (int ch = 0; ch < NUM_CH; ch++) hold[ch] = 0;
      for (int i = 0; i < 5000; i++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (hold[ch] == 0) begin
               btn[ch] = ~btn[ch];
               if ($urandom_range(0, 3) == 0) hold[ch] = int'($urandom_range(15, 40));
               else hold[ch] = int'($urandom_range(1, 6));
            end else begin
               hold[ch]--;
            end
         end
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
